// File: rtl/spi_flash_emulator.sv
// SPI NOR flash emulator (mode 0, MSB-first) decoding WREN/WRDI/RDSR/READ/PP against an internal byte array.
// Define SPI_EMU_WEL_CHECK_EN to reject PAGE PROGRAM unless the write-enable latch is set.
module spi_flash_emulator #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned PAGE_LOG2   = 8,
    parameter int unsigned PROG_CYCLES = 64,
    parameter logic [7:0]  INIT_BYTE   = 8'hFF
) (
    input  logic       CLKA,
    input  logic       rst_n,
    input  logic       SPI_CLK,
    input  logic       SPI_CS_n,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    output logic       wip,
    output logic [7:0] last_cmd,
    output logic       bad_cmd
);
    localparam int AW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(PROG_CYCLES + 1);
    localparam logic [AW-1:0] PAGE_MASK = AW'((1 << PAGE_LOG2) - 1);

    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_READ, ST_PROG, ST_STATUS, ST_IGNORE
    } state_t;

    logic [2:0] sck_sync, cs_sync, mosi_sync;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;

    state_t           state;
    logic [4:0]       bit_cnt;
    logic [7:0]       shift_in;
    logic [AW-1:0]    addr;
    logic [7:0]       out_shift;
    logic [2:0]       out_cnt;
    logic             wel, wel_set_pend, wel_clr_pend, wrote;
    logic [CNT_W-1:0] prog_cnt;

    // NOTE: the array sits outside the reset domain so its contents survive rst_n.
    logic [7:0] mem [DEPTH] = '{default: INIT_BYTE};

    logic [7:0]    rx_byte;
    logic [AW-1:0] addr_next_page;
    logic [7:0]    load_byte;
    logic          prog_byte_done;

    assign rx_byte        = {shift_in[6:0], mosi_sync[2]};
    assign addr_next_page = (addr & ~PAGE_MASK) | ((addr + 1'b1) & PAGE_MASK);
    assign load_byte      = (state == ST_READ) ? mem[addr] : {6'b0, wel, wip};
    assign prog_byte_done = sck_rise && !cs_rise && (state == ST_PROG) && (bit_cnt == 5'd7);

    // Two synchroniser flops, a third for edge history; the edge pulses are registered.
    always_ff @(posedge CLKA or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
            cs_rise   <= 1'b0;
            cs_fall   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[1:0], SPI_CLK};
            cs_sync   <= {cs_sync[1:0], SPI_CS_n};
            mosi_sync <= {mosi_sync[1:0], SPI_MOSI};
            sck_rise  <= sck_sync[1] & ~sck_sync[2];
            sck_fall  <= ~sck_sync[1] & sck_sync[2];
            cs_rise   <= cs_sync[1] & ~cs_sync[2];
            cs_fall   <= ~cs_sync[1] & cs_sync[2];
        end
    end

    always_ff @(posedge CLKA) begin
        if (prog_byte_done) mem[addr] <= rx_byte;
    end

    always_ff @(posedge CLKA or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift_in     <= '0;
            addr         <= '0;
            out_shift    <= '0;
            out_cnt      <= '0;
            wel          <= 1'b0;
            wel_set_pend <= 1'b0;
            wel_clr_pend <= 1'b0;
            wrote        <= 1'b0;
            prog_cnt     <= '0;
            wip          <= 1'b0;
            SPI_MISO     <= 1'b0;
            last_cmd     <= 8'h00;
            bad_cmd      <= 1'b0;
        end else begin
            bad_cmd <= 1'b0;
            if (wip) begin
                if (prog_cnt == CNT_W'(1)) wip <= 1'b0;
                prog_cnt <= prog_cnt - 1'b1;
            end

            // cs_rise takes priority over any SCK edge in the same cycle.
            if (cs_rise) begin
                state        <= ST_IDLE;
                SPI_MISO     <= 1'b0;
                wel_set_pend <= 1'b0;
                wel_clr_pend <= 1'b0;
                if (wel_set_pend) wel <= 1'b1;
                if (wel_clr_pend) wel <= 1'b0;
                if (state == ST_PROG && wrote) begin
                    wip      <= 1'b1;
                    prog_cnt <= CNT_W'(PROG_CYCLES);
                    wel      <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state    <= ST_CMD;
                            bit_cnt  <= '0;
                            shift_in <= '0;
                            wrote    <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            shift_in <= rx_byte;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt  <= '0;
                                out_cnt  <= '0;
                                last_cmd <= rx_byte;
                                if (wip && rx_byte != OP_RDSR) begin
                                    state <= ST_IGNORE;
                                end else begin
                                    case (rx_byte)
                                        OP_WREN: begin
                                            wel_set_pend <= 1'b1;
                                            state        <= ST_IGNORE;
                                        end
                                        OP_WRDI: begin
                                            wel_clr_pend <= 1'b1;
                                            state        <= ST_IGNORE;
                                        end
                                        OP_RDSR: state <= ST_STATUS;
                                        OP_READ: state <= ST_ADDR;
`ifdef SPI_EMU_WEL_CHECK_EN
                                        OP_PP:   state <= wel ? ST_ADDR : ST_IGNORE;
`else
                                        OP_PP:   state <= ST_ADDR;
`endif
                                        default: begin
                                            bad_cmd <= 1'b1;
                                            state   <= ST_IGNORE;
                                        end
                                    endcase
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            addr    <= {addr[AW-2:0], mosi_sync[2]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                state   <= (last_cmd == OP_READ) ? ST_READ : ST_PROG;
                            end
                        end
                    end
                    ST_READ, ST_STATUS: begin
                        // A fresh byte is loaded at every byte boundary, then shifted out MSB-first.
                        if (sck_fall) begin
                            if (out_cnt == 3'd0) begin
                                SPI_MISO  <= load_byte[7];
                                out_shift <= {load_byte[6:0], 1'b0};
                                out_cnt   <= 3'd7;
                                if (state == ST_READ) addr <= addr + 1'b1;
                            end else begin
                                SPI_MISO  <= out_shift[7];
                                out_shift <= {out_shift[6:0], 1'b0};
                                out_cnt   <= out_cnt - 1'b1;
                            end
                        end
                    end
                    ST_PROG: begin
                        if (sck_rise) begin
                            shift_in <= rx_byte;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                addr    <= addr_next_page;
                                wrote   <= 1'b1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        // Any extra clock after WREN/WRDI voids the pending latch update.
                        if (sck_rise) begin
                            wel_set_pend <= 1'b0;
                            wel_clr_pend <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_emulator.sv
// Self-checking bench for spi_flash_emulator: directed vector table, corner sequences, and random ops vs a byte-array model.
module tb_spi_flash_emulator;
    localparam int HALF        = 5;
    localparam int PROG_CYCLES = 64;
    localparam int DEPTH       = 1024;
    localparam int PAGE        = 256;
`ifdef SPI_EMU_WEL_CHECK_EN
    localparam bit WEL_GATE = 1'b1;
`else
    localparam bit WEL_GATE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       wip;
    logic [7:0] last_cmd;
    logic       bad_cmd;

    always #5 clk = ~clk;

    spi_flash_emulator dut (
        .CLKA    (clk),
        .rst_n   (rst_n),
        .SPI_CLK (sck),
        .SPI_CS_n(cs_n),
        .SPI_MOSI(mosi),
        .SPI_MISO(miso),
        .wip     (wip),
        .last_cmd(last_cmd),
        .bad_cmd (bad_cmd)
    );

    int checks = 0;
    int errors = 0;
    int miso_hi = 0;
    int bad_hi = 0;

    logic [7:0] mem_m [DEPTH];
    bit         wel_m;

    always @(negedge clk) begin
        if (miso === 1'b1) miso_hi++;
        if (bad_cmd === 1'b1) bad_hi++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_cyc(HALF);
            rx = {rx[6:0], miso};
            sck = 1'b1;
            wait_cyc(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic frame_begin();
        miso_hi = 0;
        bad_hi  = 0;
        cs_n    = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic frame_end();
        wait_cyc(HALF);
        cs_n = 1'b1;
    endtask

    task automatic frame(input logic [7:0] op, input logic [23:0] a, input int n,
                         input logic [31:0] wd, output logic [31:0] rd);
        logic [7:0] b;
        rd = 32'h0;
        frame_begin();
        xfer_bits(op, 8, b);
        if (op == 8'h03 || op == 8'h02) begin
            xfer_bits(a[23:16], 8, b);
            xfer_bits(a[15:8], 8, b);
            xfer_bits(a[7:0], 8, b);
        end
        for (int i = 0; i < n; i++) begin
            xfer_bits(wd[8*(n-1-i) +: 8], 8, b);
            rd = {rd[23:0], b};
        end
        frame_end();
    endtask

    task automatic measure_wip(output int hi);
        int waited;
        waited = 0;
        hi = 0;
        while (wip !== 1'b1 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        while (wip === 1'b1 && hi < 300) begin
            @(negedge clk);
            hi++;
        end
        wait_cyc(8);
    endtask

    // Behavioural model: a flat byte array, a WEL flag, page-wrapped programming.
    task automatic model_apply(input logic [7:0] op, input logic [23:0] a, input int n,
                               input logic [31:0] wd, output logic [31:0] exp_rd, output int exp_wip);
        int base, pg;
        exp_rd  = 32'h0;
        exp_wip = 0;
        base    = int'(a) % DEPTH;
        pg      = base - (base % PAGE);
        case (op)
            8'h06: wel_m = 1'b1;
            8'h04: wel_m = 1'b0;
            8'h05: for (int i = 0; i < n; i++) exp_rd = {exp_rd[23:0], 6'b0, wel_m, 1'b0};
            8'h03: for (int i = 0; i < n; i++) exp_rd = {exp_rd[23:0], mem_m[(base + i) % DEPTH]};
            8'h02: begin
                if (n > 0 && (wel_m || !WEL_GATE)) begin
                    for (int i = 0; i < n; i++)
                        mem_m[pg + ((base % PAGE) + i) % PAGE] = wd[8*(n-1-i) +: 8];
                    wel_m   = 1'b0;
                    exp_wip = PROG_CYCLES;
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [23:0] a, input int n,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_wip,
                          input bit exp_bad);
        logic [31:0] rd;
        int hi;
        frame(op, a, n, wd, rd);
        measure_wip(hi);
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " last_cmd"}, last_cmd, op);
        check({tag, " wip_cycles"}, hi, exp_wip);
        check({tag, " bad_cmd_cycles"}, bad_hi, exp_bad);
        if (op != 8'h03 && op != 8'h05) check({tag, " miso_quiet"}, miso_hi, 0);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          n;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_wip;
        bit          exp_bad;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] e_rd;
        int          e_wip;
        logic [7:0]  b;
        logic [31:0] rd;
        int          hi;
        logic [23:0] a;
        int          n;
        logic [31:0] wd;

        vecs[0]  = '{8'h05, 24'h000000, 1, 32'h0,      32'h00,       0, 1'b0};
        vecs[1]  = '{8'h03, 24'h000010, 3, 32'h0,      32'hFFFFFF,   0, 1'b0};
        vecs[2]  = '{8'h06, 24'h000000, 0, 32'h0,      32'h0,        0, 1'b0};
        vecs[3]  = '{8'h05, 24'h000000, 2, 32'h0,      32'h0202,     0, 1'b0};
        vecs[4]  = '{8'h02, 24'h0000FE, 3, 32'hA1A2A3, 32'h0,        PROG_CYCLES, 1'b0};
        vecs[5]  = '{8'h05, 24'h000000, 1, 32'h0,      32'h00,       0, 1'b0};
        vecs[6]  = '{8'h03, 24'h0000FE, 2, 32'h0,      32'hA1A2,     0, 1'b0};
        vecs[7]  = '{8'h03, 24'h000000, 1, 32'h0,      32'hA3,       0, 1'b0};
        vecs[8]  = '{8'h9F, 24'h000000, 1, 32'h0,      32'h00,       0, 1'b1};
        vecs[9]  = '{8'h02, 24'h000200, 1, 32'h55,     32'h0,        WEL_GATE ? 0 : PROG_CYCLES, 1'b0};
        vecs[10] = '{8'h03, 24'h000200, 1, 32'h0,      WEL_GATE ? 32'hFF : 32'h55, 0, 1'b0};
        vecs[11] = '{8'h06, 24'h000000, 0, 32'h0,      32'h0,        0, 1'b0};
        vecs[12] = '{8'h04, 24'h000000, 0, 32'h0,      32'h0,        0, 1'b0};
        vecs[13] = '{8'h05, 24'h000000, 1, 32'h0,      32'h00,       0, 1'b0};
        vecs[14] = '{8'h03, 24'hABC0FE, 1, 32'h0,      32'hA1,       0, 1'b0};
        vecs[15] = '{8'h03, 24'h0003FF, 2, 32'h0,      32'hFFA3,     0, 1'b0};

        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
        wel_m = 1'b0;

        wait_cyc(3);
        check("reset miso", miso, 1'b0);
        check("reset wip", wip, 1'b0);
        check("reset last_cmd", last_cmd, 8'h00);
        check("reset bad_cmd", bad_cmd, 1'b0);
        rst_n = 1'b1;
        wait_cyc(5);

        for (int i = 0; i < 16; i++) begin
            model_apply(vecs[i].op, vecs[i].addr, vecs[i].n, vecs[i].wdata, e_rd, e_wip);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].n, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_wip, vecs[i].exp_bad);
        end

        // WREN followed by a ninth clock must not set WEL.
        frame_begin();
        xfer_bits(8'h06, 8, b);
        xfer_bits(8'h00, 1, b);
        frame_end();
        wait_cyc(12);
        run_op("wren9 rdsr", 8'h05, 24'h0, 1, 32'h0, 32'h00, 0, 1'b0);

        // PP aborted after 5 data bits: nothing written, no wip, WEL kept.
        run_op("partial wren", 8'h06, 24'h0, 0, 32'h0, 32'h0, 0, 1'b0);
        wel_m = 1'b1;
        frame_begin();
        xfer_bits(8'h02, 8, b);
        xfer_bits(8'h00, 8, b);
        xfer_bits(8'h03, 8, b);
        xfer_bits(8'h00, 8, b);
        xfer_bits(8'hC3, 5, b);
        frame_end();
        measure_wip(hi);
        check("partial wip_cycles", hi, 0);
        check("partial miso_quiet", miso_hi, 0);
        run_op("partial rdsr", 8'h05, 24'h0, 1, 32'h0, 32'h02, 0, 1'b0);
        run_op("partial read", 8'h03, 24'h000300, 1, 32'h0, 32'hFF, 0, 1'b0);
        run_op("partial wrdi", 8'h04, 24'h0, 0, 32'h0, 32'h0, 0, 1'b0);
        wel_m = 1'b0;

        // Reset asserted in the middle of a READ byte.
        frame_begin();
        xfer_bits(8'h03, 8, b);
        xfer_bits(8'h00, 8, b);
        xfer_bits(8'h00, 8, b);
        xfer_bits(8'hFE, 8, b);
        xfer_bits(8'h00, 3, b);
        check("midread partial bits", b, 8'h05);
        rst_n = 1'b0;
        wait_cyc(2);
        check("midreset miso", miso, 1'b0);
        check("midreset wip", wip, 1'b0);
        check("midreset last_cmd", last_cmd, 8'h00);
        check("midreset bad_cmd", bad_cmd, 1'b0);
        cs_n = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(10);
        run_op("postreset rdsr", 8'h05, 24'h0, 1, 32'h0, 32'h00, 0, 1'b0);
        run_op("postreset read", 8'h03, 24'h0000FE, 2, 32'h0, 32'hA1A2, 0, 1'b0);

        // Randomised traffic against the model.
        for (int k = 0; k < 12; k++) begin
            a = 24'($urandom);
            if ($urandom_range(0, 1) == 1) a[7:0] = 8'hFC + 8'($urandom_range(0, 3));
            n = $urandom_range(1, 4);
            wd = $urandom;
            case ($urandom_range(0, 2))
                0: begin
                    model_apply(8'h03, a, n, 32'h0, e_rd, e_wip);
                    run_op($sformatf("rnd%0d read", k), 8'h03, a, n, 32'h0, e_rd, e_wip, 1'b0);
                end
                1: begin
                    model_apply(8'h06, a, 0, 32'h0, e_rd, e_wip);
                    run_op($sformatf("rnd%0d wren", k), 8'h06, a, 0, 32'h0, e_rd, e_wip, 1'b0);
                    if (n < 4) wd = wd & ((32'h1 << (8 * n)) - 1);
                    model_apply(8'h02, a, n, wd, e_rd, e_wip);
                    run_op($sformatf("rnd%0d pp", k), 8'h02, a, n, wd, e_rd, e_wip, 1'b0);
                    model_apply(8'h03, a, 4, 32'h0, e_rd, e_wip);
                    run_op($sformatf("rnd%0d readback", k), 8'h03, a, 4, 32'h0, e_rd, e_wip, 1'b0);
                end
                default: begin
                    n = $urandom_range(1, 2);
                    model_apply(8'h05, a, n, 32'h0, e_rd, e_wip);
                    run_op($sformatf("rnd%0d rdsr", k), 8'h05, a, n, 32'h0, e_rd, e_wip, 1'b0);
                end
            endcase
        end

        frame(8'h03, 24'h0000FE, 1, 32'h0, rd);
        measure_wip(hi);
        model_apply(8'h03, 24'h0000FE, 1, 32'h0, e_rd, e_wip);
        check("final read", rd, e_rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_flash_emulator.md
# spi_flash_emulator

- Synthesizable single-clock emulator of an SPI NOR flash, mode 0, MSB-first.
- Replaces the constant-zero MISO tie-off in the system bench; it can also be placed on the FPGA in front of the real memory pins.
- Oversamples SPI_CLK/SPI_CS_n/SPI_MOSI on CLKA and decodes WREN, WRDI, RDSR, READ and PAGE PROGRAM against an internal byte array.
- Array depth, page size and program delay are parametrised.

## Interface
- DEPTH_LOG2, 10: array holds 2^DEPTH_LOG2 bytes; address is taken modulo depth.
- PAGE_LOG2, 8: page size for program wrap; must be ≤ DEPTH_LOG2.
- PROG_CYCLES, 64: CLKA cycles that WIP stays high after a program.
- INIT_BYTE, 8'hFF: array content at time zero; rst_n does not clear the array.
- Clock and reset: one clock; reset is asynchronous and active-low.
- CLKA  in  1  system clock; SPI_CLK must run at ≤ CLKA/8.
- rst_n  in  1  asynchronous active-low reset.
- SPI_CLK  in  1  serial clock from master, asynchronous to CLKA.
- SPI_CS_n  in  1  chip select, active-low.
- SPI_MOSI  in  1  serial data in.
- SPI_MISO  out  1  serial data out; reset 0.
- wip  out  1  program in progress; reset 0.
- last_cmd  out  8  opcode of the most recent decoded command; reset 8'h00.
- bad_cmd  out  1  one-cycle pulse on an unsupported opcode; reset 0.

## Operation
- Input synchronisation:
  - SPI_CLK, SPI_CS_n and SPI_MOSI each pass through a 2-FF synchroniser.
  - Edge detectors produce sck_rise, sck_fall, cs_fall and cs_rise.
  - MOSI is sampled on sck_rise.
  - MISO is updated on sck_fall.
- States: IDLE, CMD, ADDR, READ, PROG, STATUS, IGNORE.
- IDLE:
  - cs_fall goes to CMD; the bit counter and shift register clear.
- CMD, after 8 bits:
  - Latch last_cmd.
  - If wip=1, any opcode other than 8'h05 goes to IGNORE.
  - 8'h06 WREN: WEL is set at cs_rise, and only if exactly 8 bits were clocked.
  - 8'h04 WRDI: WEL is cleared at cs_rise under the same 8-bit rule.
  - 8'h05 RDSR goes to STATUS.
  - 8'h03 READ goes to ADDR, then READ.
  - 8'h02 PP goes to ADDR, then PROG.
  - Any other opcode pulses bad_cmd and goes to IGNORE.
- ADDR: 24 bits, MSB-first. Only the low DEPTH_LOG2 bits are kept.
- READ:
  - On the sck_fall that follows the last address bit, load mem[addr] into the output shift register.
  - Shift one bit per sck_fall.
  - After each 8 bits, addr increments modulo 2^DEPTH_LOG2 and the next byte loads.
- STATUS: streams {6'b0, WEL, wip} repeatedly; each byte is re-sampled at its byte boundary.
- PROG:
  - Each complete received byte is written to mem[addr].
  - addr then increments within the page: the low PAGE_LOG2 bits wrap and the upper bits are held.
- End of a PP: at cs_rise, if at least one byte was written, set wip, start the PROG_CYCLES down-counter and clear WEL.
- IGNORE: MISO stays 0 and nothing is written.
- Any state:
  - cs_rise returns to IDLE.
  - A partial byte is discarded and never written.
  - MISO goes to 0 on the following cycle.
- MISO is 0 whenever the state is not READ or STATUS.
- Reset mid-transfer:
  - State → IDLE; WEL, wip and counter clear; outputs go to their reset values.
  - Array contents are preserved.

## Timing
- Synchroniser plus edge detect: the registered edge pulse occurs 3 CLKA cycles after the pin edge.
- MISO changes no more than 4 CLKA cycles after the SPI_CLK falling pin edge. At CLKA/8 this is valid before the next rising edge.
- Array write: 1 CLKA cycle after the sck_rise that completes the byte.
- wip rises 1 cycle after cs_rise and falls exactly PROG_CYCLES cycles later.
- RDSR issued while wip=1 returns bit0=1 until the counter expires. The byte sampled after expiry returns bit0=0.
- Simultaneous cs_rise and sck_rise in the same cycle: cs_rise wins and the bit is discarded.

## Configuration
- SPI_EMU_WEL_CHECK_EN defined:
  - PP is accepted only if WEL=1; otherwise it goes to IGNORE with no write and no wip.
- Not defined:
  - PP is always accepted.
  - WREN and WRDI are still decoded but WEL has no gating effect.
  - The status WEL bit still reflects the register.

## Test plan
- Reset, then RDSR → MISO byte 8'h00, wip=0, last_cmd=8'h05.
- READ addr 24'h000010, 3 bytes after reset → 8'hFF ×3.
- WREN, then PP addr 0x0000FE with bytes 0xA1, 0xA2, 0xA3 → wip high for 64 cycles. READ 0x0000FE gives 0xA1, 0xA2. READ 0x000000 gives 0xA3 (page wrap).
- With SPI_EMU_WEL_CHECK_EN: PP without WREN, data 0x55 → no write, wip stays 0, READ returns 0xFF. Without the macro, READ returns 0x55.
- Opcode 8'h9F → bad_cmd one-cycle pulse, MISO 0 for the whole frame.
- CS_n deasserted after 5 data bits of a PP byte, then reset asserted mid-READ → no write, state IDLE, MISO=0, and previously written data intact on re-read.
